siso_pkt: RTL and testbench

Byte-stream packet FIFO replacing the plain `siso` buffers between the ROS2 core and the IP TX/RX adapters. Parametrised in data width, depth and mode. In packet mode it exposes a frame to the reader only after its last byte is written. Frames that are aborted or overflow are rewound and dropped, so a partial frame never reaches `ip_tx` or the ROS2 core.

---
 rtl/siso_pkt_if.sv | 32 +++
 rtl/siso_pkt.sv | 153 +++++++++++++++
 tb/tb_siso_pkt.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/siso_pkt_if.sv
// Write/read bundle of the packet FIFO. The master side is the producer/consumer,
// the slave side is the FIFO itself.
interface siso_pkt_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 2048
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] din;
  logic                  wr_last;
  logic                  wr_abort;
  logic                  full;
  logic                  almost_full;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_last;
  logic                  empty;
  logic [AW:0]           level;
  logic [AW:0]           pkt_count;
  logic                  drop;

  modport master (
    output wr_en, din, wr_last, wr_abort, rd_en,
    input  full, almost_full, dout, dout_last, empty, level, pkt_count, drop
  );

  modport slave (
    input  wr_en, din, wr_last, wr_abort, rd_en,
    output full, almost_full, dout, dout_last, empty, level, pkt_count, drop
  );
endinterface

// File: rtl/siso_pkt.sv
// Byte-stream packet FIFO. In packet mode frames become readable only once their
// last byte is written; aborted or overflowing frames are rewound and dropped.
module siso_pkt #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 2048,
  parameter int unsigned PKT_MODE   = 1,
  parameter int unsigned AF_MARGIN  = 16
) (
  input logic        clk,
  input logic        reset_n,
  siso_pkt_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef logic [AW:0] ptr_t;
  localparam ptr_t DepthP = ptr_t'(DEPTH);
  localparam ptr_t AfThr  = ptr_t'(DEPTH - AF_MARGIN);
  localparam ptr_t PtrOne = ptr_t'(1);

  typedef enum logic [0:0] {StAccept, StDrop} state_e;

  logic [DATA_WIDTH:0] mem [DEPTH];
  logic [DATA_WIDTH:0] head;

  ptr_t   wr_ptr_q, wr_ptr_d;
  ptr_t   cm_ptr_q, cm_ptr_d;
  ptr_t   rd_ptr_q;
  ptr_t   pkt_cnt_q, pkt_cnt_d;
  ptr_t   used, level;
  logic   full, empty, rd_fire, head_last;
  logic   mem_we, pkt_inc, pkt_dec;
  logic   drop_q, drop_d;
  state_e state_q, state_d;

  // wr_ptr is speculative; only cm_ptr bounds what the reader can see.
  assign used      = wr_ptr_q - rd_ptr_q;
  assign level     = cm_ptr_q - rd_ptr_q;
  assign full      = (used == DepthP);
  assign empty     = (level == '0);
  assign head      = mem[rd_ptr_q[AW-1:0]];
  assign head_last = head[DATA_WIDTH];
  assign rd_fire   = bus.rd_en & ~empty;
  assign pkt_dec   = rd_fire & head_last;

  assign bus.full        = full;
  assign bus.almost_full = (used >= AfThr);
  assign bus.dout        = head[DATA_WIDTH-1:0];
  assign bus.dout_last   = head_last;
  assign bus.empty       = empty;
  assign bus.level       = level;
  assign bus.pkt_count   = pkt_cnt_q;
  assign bus.drop        = drop_q;

  // State register, including the registered drop pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StAccept;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
    end
  end

  // Next state: an overflow without wr_last discards the rest of the frame.
  always_comb begin
    state_d = state_q;
    if (PKT_MODE == 0) begin
      state_d = StAccept;
    end else begin
      unique case (state_q)
        StAccept: begin
          if (!bus.wr_abort && bus.wr_en && full && !bus.wr_last) state_d = StDrop;
        end
        StDrop: begin
          if (bus.wr_abort || (bus.wr_en && bus.wr_last)) state_d = StAccept;
        end
        default: state_d = StAccept;
      endcase
    end
  end

  // Outputs: pointer moves, array write enable and drop pulse.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    cm_ptr_d = cm_ptr_q;
    mem_we   = 1'b0;
    pkt_inc  = 1'b0;
    drop_d   = 1'b0;
    if (PKT_MODE == 0) begin
      if (bus.wr_en && !full) begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + PtrOne;
        cm_ptr_d = wr_ptr_q + PtrOne;
        pkt_inc  = bus.wr_last;
      end
    end else begin
      unique case (state_q)
        StAccept: begin
          if (bus.wr_abort || (bus.wr_en && full)) begin
            // Rewind the partial frame; abort also wins over wr_last.
            wr_ptr_d = cm_ptr_q;
            drop_d   = 1'b1;
          end else if (bus.wr_en) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PtrOne;
            if (bus.wr_last) begin
              cm_ptr_d = wr_ptr_q + PtrOne;
              pkt_inc  = 1'b1;
            end
          end
        end
        StDrop: begin
          // wr_ptr already equals cm_ptr; everything is discarded here.
        end
        default: begin
        end
      endcase
    end
  end

  // Commit and read of a last byte on the same edge cancel out.
  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (pkt_inc && !pkt_dec) begin
      pkt_cnt_d = pkt_cnt_q + PtrOne;
    end else if (!pkt_inc && pkt_dec) begin
      pkt_cnt_d = pkt_cnt_q - PtrOne;
    end
  end

  // Pointer and frame-counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      cm_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      pkt_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      cm_ptr_q  <= cm_ptr_d;
      pkt_cnt_q <= pkt_cnt_d;
      if (rd_fire) rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  // Storage array, data plus the wr_last flag; not reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr_q[AW-1:0]] <= {bus.wr_last, bus.din};
  end

endmodule

// File: tb/tb_siso_pkt.sv
// Directed bench: one packet-mode and one plain-mode instance, both DEPTH=16.
module tb_siso_pkt;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  siso_pkt_if #(.DATA_WIDTH(8), .DEPTH(16)) b1 ();
  siso_pkt_if #(.DATA_WIDTH(8), .DEPTH(16)) b0 ();

  siso_pkt #(.DATA_WIDTH(8), .DEPTH(16), .PKT_MODE(1), .AF_MARGIN(4)) dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (b1)
  );

  siso_pkt #(.DATA_WIDTH(8), .DEPTH(16), .PKT_MODE(0), .AF_MARGIN(4)) dut0 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (b0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic w1(input logic [7:0] d, input logic last, input logic abort);
    b1.wr_en = 1'b1; b1.din = d; b1.wr_last = last; b1.wr_abort = abort;
    step();
    b1.wr_en = 1'b0; b1.wr_last = 1'b0; b1.wr_abort = 1'b0;
  endtask

  task automatic r1_chk(input string tag, input logic [7:0] d, input logic last);
    check({tag, "_dout"}, b1.dout, d);
    check({tag, "_last"}, b1.dout_last, last);
    b1.rd_en = 1'b1;
    step();
    b1.rd_en = 1'b0;
  endtask

  function automatic logic [7:0] m0d(input int i);
    return 8'(i) ^ 8'h5A;
  endfunction

  initial begin
    b1.wr_en = 0; b1.din = '0; b1.wr_last = 0; b1.wr_abort = 0; b1.rd_en = 0;
    b0.wr_en = 0; b0.din = '0; b0.wr_last = 0; b0.wr_abort = 0; b0.rd_en = 0;

    // Reset state
    #12;
    check("rst_empty", b1.empty, 1);
    check("rst_full", b1.full, 0);
    check("rst_af", b1.almost_full, 0);
    check("rst_level", b1.level, 0);
    check("rst_pkt", b1.pkt_count, 0);
    check("rst_drop", b1.drop, 0);
    check("rst_empty0", b0.empty, 1);
    reset_n = 1'b1;
    step();

    // Basic 5-byte frame, visible only after its last byte
    for (int i = 1; i <= 5; i++) begin
      w1(8'(i), (i == 5), 1'b0);
      check("t1_empty", b1.empty, (i < 5));
    end
    check("t1_level", b1.level, 5);
    check("t1_pkt", b1.pkt_count, 1);
    for (int i = 1; i <= 5; i++) r1_chk("t1_rd", 8'(i), (i == 5));
    check("t1_empty_end", b1.empty, 1);
    check("t1_pkt_end", b1.pkt_count, 0);

    // Abort: frame A committed, frame B aborted
    w1(8'hA1, 0, 0); w1(8'hA2, 0, 0); w1(8'hA3, 1, 0);
    for (int i = 1; i <= 4; i++) begin
      w1(8'hB0 + 8'(i), 0, 0);
      check("t2_nodrop", b1.drop, 0);
    end
    w1(8'hFF, 1, 1);  // abort with wr_en+wr_last: byte discarded, abort wins
    check("t2_drop", b1.drop, 1);
    check("t2_level", b1.level, 3);
    check("t2_pkt", b1.pkt_count, 1);
    step();
    check("t2_drop_once", b1.drop, 0);
    r1_chk("t2_rd", 8'hA1, 0); r1_chk("t2_rd", 8'hA2, 0); r1_chk("t2_rd", 8'hA3, 1);
    check("t2_empty", b1.empty, 1);

    // Overflow: 20-byte frame into 16 entries
    for (int i = 1; i <= 20; i++) begin
      w1(8'h40 + 8'(i), (i == 20), 0);
      check("t3_drop", b1.drop, (i == 17));
      check("t3_empty", b1.empty, 1);
      check("t3_full", b1.full, (i == 16));
      check("t3_af", b1.almost_full, (i >= 12 && i <= 16));
    end
    w1(8'h71, 0, 0); w1(8'h72, 1, 0);
    check("t3_drop_after", b1.drop, 0);
    check("t3_level", b1.level, 2);
    check("t3_pkt", b1.pkt_count, 1);
    r1_chk("t3_rd", 8'h71, 0); r1_chk("t3_rd", 8'h72, 1);
    check("t3_empty_end", b1.empty, 1);

    // Commit of frame D's last byte on the same edge as frame C's last byte is read
    w1(8'hC1, 0, 0); w1(8'hC2, 1, 0); w1(8'hD1, 0, 0);
    r1_chk("t5_rd", 8'hC1, 0);
    check("t5_head_last", b1.dout_last, 1);
    b1.rd_en = 1'b1;
    w1(8'hD2, 1, 0);
    b1.rd_en = 1'b0;
    check("t5_pkt", b1.pkt_count, 1);
    check("t5_level", b1.level, 2);
    r1_chk("t5_rd", 8'hD1, 0); r1_chk("t5_rd", 8'hD2, 1);
    check("t5_pkt_end", b1.pkt_count, 0);

    // Mode 0 wrap: 100 bytes streamed with a steady level of 3
    for (int i = 0; i < 100; i++) begin
      b0.wr_en = 1'b1; b0.din = m0d(i); b0.wr_last = (i % 10 == 9);
      b0.wr_abort = (i == 50);  // ignored in plain mode
      b0.rd_en = (i >= 3);
      if (i >= 3) begin
        check("t4_dout", b0.dout, m0d(i - 3));
        check("t4_last", b0.dout_last, ((i - 3) % 10 == 9));
      end
      step();
      if (i == 0) check("t4_empty0", b0.empty, 0);
      check("t4_full", b0.full, 0);
      check("t4_level", b0.level, (i < 3) ? i + 1 : 3);
    end
    b0.wr_en = 0; b0.wr_last = 0; b0.wr_abort = 0; b0.rd_en = 0;
    for (int i = 97; i < 100; i++) begin
      check("t4_drain", b0.dout, m0d(i));
      check("t4_drain_last", b0.dout_last, (i % 10 == 9));
      b0.rd_en = 1'b1; step(); b0.rd_en = 1'b0;
    end
    check("t4_empty", b0.empty, 1);
    check("t4_pkt", b0.pkt_count, 0);

    // Mode 0 full: 17th write is ignored
    for (int i = 0; i < 17; i++) begin
      b0.wr_en = 1'b1; b0.din = 8'h80 + 8'(i);
      step();
      check("t4f_full", b0.full, (i >= 15));
    end
    b0.wr_en = 1'b0;
    check("t4f_level", b0.level, 16);
    for (int i = 0; i < 16; i++) begin
      check("t4f_dout", b0.dout, 8'h80 + 8'(i));
      b0.rd_en = 1'b1; step(); b0.rd_en = 1'b0;
    end
    check("t4f_empty", b0.empty, 1);

    // Reset mid-frame with two committed frames held
    w1(8'hE1, 1, 0); w1(8'hF1, 0, 0); w1(8'hF2, 1, 0); w1(8'h91, 0, 0);
    check("t6_pkt_pre", b1.pkt_count, 2);
    check("t6_level_pre", b1.level, 3);
    reset_n = 1'b0;
    #1;
    check("t6_empty", b1.empty, 1);
    check("t6_pkt", b1.pkt_count, 0);
    check("t6_level", b1.level, 0);
    check("t6_drop", b1.drop, 0);
    step();
    check("t6_drop_hold", b1.drop, 0);
    reset_n = 1'b1;
    step();
    check("t6_empty_after", b1.empty, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
